// File: rtl/vga_fetch_ctrl.sv
// Frame-buffer fetch scheduler: on each vsync, streams one frame of pixels from memory
// into a first-word fall-through pixel FIFO, keeping at most one burst outstanding.
module vga_fetch_ctrl #(
    parameter int unsigned H_PIXELS   = 640,
    parameter int unsigned V_LINES    = 480,
    parameter int unsigned BURST      = 8,
    parameter int unsigned FIFO_DEPTH = 64
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        enable,
    input  logic [31:0]                 fb_base,
    input  logic                        vsync,
    output logic [23:0]                 pixel_color,
    input  logic                        pixel_taken,
    output logic                        mem_req,
    output logic [31:0]                 mem_addr,
    input  logic                        mem_ack,
    input  logic                        mem_rvalid,
    input  logic [31:0]                 mem_rdata,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level,
    output logic                        underflow,
    output logic                        busy
);
    localparam int unsigned AW          = $clog2(FIFO_DEPTH);
    localparam int unsigned LW          = AW + 1;
    localparam int unsigned BW          = (BURST > 1) ? $clog2(BURST) : 1;
    localparam logic [31:0] FRAME_WORDS = 32'(H_PIXELS * V_LINES);
    localparam logic [31:0] BURST_WORDS = 32'(BURST);
    localparam logic [31:0] BURST_BYTES = 32'(4 * BURST);
    localparam logic [LW-1:0] SPACE_MAX = LW'(FIFO_DEPTH - BURST);
    localparam logic [BW-1:0] LAST_BEAT = BW'(BURST - 1);

    typedef enum logic [1:0] {StIdle, StWaitSpace, StReq, StData} state_e;

    state_e        state_q, state_d;
    logic [31:0]   addr_q, addr_d;
    logic [31:0]   words_left_q, words_left_d;
    logic [BW-1:0] beat_cnt_q, beat_cnt_d;
    logic          resync_pending_q, resync_pending_d;
    logic          discard_q, discard_d;
    logic [31:0]   base_lat_q, base_lat_d;
    logic          en_lat_q, en_lat_d;
    logic          underflow_q, underflow_d;

    logic [23:0]   fifo_mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [LW-1:0] count_q;
    logic          fifo_empty, push, pop, flush, clr_underflow;

    // A vsync arriving on the very cycle of the last beat must still win the restart.
    logic          pending_now, en_now;
    logic [31:0]   base_now;

    logic          unused_rdata;
    assign unused_rdata = ^mem_rdata[31:24];

    assign fifo_empty  = (count_q == '0);
    assign pop         = pixel_taken && !fifo_empty;
    assign pending_now = resync_pending_q || vsync;
    assign en_now      = vsync ? enable : en_lat_q;
    assign base_now    = vsync ? fb_base : base_lat_q;

    always_comb begin
        state_d          = state_q;
        addr_d           = addr_q;
        words_left_d     = words_left_q;
        beat_cnt_d       = beat_cnt_q;
        resync_pending_d = resync_pending_q;
        discard_d        = discard_q;
        base_lat_d       = base_lat_q;
        en_lat_d         = en_lat_q;
        flush            = 1'b0;
        push             = 1'b0;
        clr_underflow    = 1'b0;

        unique case (state_q)
            StIdle, StWaitSpace: begin
                if (vsync) begin
                    flush = 1'b1;
                    if (enable) begin
                        state_d       = StWaitSpace;
                        addr_d        = fb_base;
                        words_left_d  = FRAME_WORDS;
                        clr_underflow = 1'b1;
                    end else begin
                        state_d = StIdle;
                    end
                end else if (state_q == StWaitSpace && count_q <= SPACE_MAX) begin
                    state_d = StReq;
                end
            end
            StReq, StData: begin
                if (vsync) begin
                    flush            = 1'b1;
                    resync_pending_d = 1'b1;
                    discard_d        = 1'b1;
                    base_lat_d       = fb_base;
                    en_lat_d         = enable;
                end
                if (state_q == StReq) begin
                    if (mem_ack) begin
                        beat_cnt_d = '0;
                        state_d    = StData;
                    end
                end else if (mem_rvalid) begin
                    beat_cnt_d = beat_cnt_q + BW'(1);
                    push       = !discard_q;
                    if (beat_cnt_q == LAST_BEAT) begin
                        addr_d       = addr_q + BURST_BYTES;
                        words_left_d = words_left_q - BURST_WORDS;
                        if (pending_now) begin
                            flush            = 1'b1;
                            resync_pending_d = 1'b0;
                            discard_d        = 1'b0;
                            if (en_now) begin
                                state_d       = StWaitSpace;
                                addr_d        = base_now;
                                words_left_d  = FRAME_WORDS;
                                clr_underflow = 1'b1;
                            end else begin
                                state_d = StIdle;
                            end
                        end else if (words_left_q == BURST_WORDS) begin
                            state_d = StIdle;
                        end else begin
                            state_d = StWaitSpace;
                        end
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        underflow_d = clr_underflow ? 1'b0 : (underflow_q || (pixel_taken && fifo_empty));
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q          <= StIdle;
            addr_q           <= '0;
            words_left_q     <= '0;
            beat_cnt_q       <= '0;
            resync_pending_q <= 1'b0;
            discard_q        <= 1'b0;
            base_lat_q       <= '0;
            en_lat_q         <= 1'b0;
            underflow_q      <= 1'b0;
        end else begin
            state_q          <= state_d;
            addr_q           <= addr_d;
            words_left_q     <= words_left_d;
            beat_cnt_q       <= beat_cnt_d;
            resync_pending_q <= resync_pending_d;
            discard_q        <= discard_d;
            base_lat_q       <= base_lat_d;
            en_lat_q         <= en_lat_d;
            underflow_q      <= underflow_d;
        end
    end

    // Flush takes priority over any push or pop in the same cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            if (push && !pop) begin
                count_q <= count_q + LW'(1);
            end else if (pop && !push) begin
                count_q <= count_q - LW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push && !flush) begin
            fifo_mem[wr_ptr_q] <= mem_rdata[23:0];
        end
    end

    assign pixel_color = fifo_empty ? 24'h0 : fifo_mem[rd_ptr_q];
    assign mem_req     = (state_q == StReq);
    assign mem_addr    = addr_q;
    assign busy        = (state_q != StIdle);
    assign fifo_level  = count_q;
    assign underflow   = underflow_q;

endmodule

// File: tb/tb_vga_fetch_ctrl.sv
// Self-checking bench for vga_fetch_ctrl: a randomized memory slave feeds address-derived
// pixels, and every popped pixel is checked against its frame position.
module tb_vga_fetch_ctrl;
    localparam int unsigned H_PIXELS     = 16;
    localparam int unsigned V_LINES      = 8;
    localparam int unsigned BURST        = 8;
    localparam int unsigned FIFO_DEPTH   = 64;
    localparam int unsigned FRAME_WORDS  = H_PIXELS * V_LINES;
    localparam int unsigned FRAME_BURSTS = FRAME_WORDS / BURST;

    logic        clk = 1'b0;
    logic        reset_n, enable, vsync, pixel_taken;
    logic [31:0] fb_base;
    logic [23:0] pixel_color;
    logic        mem_req, mem_ack, mem_rvalid;
    logic [31:0] mem_addr, mem_rdata;
    logic [6:0]  fifo_level;
    logic        underflow, busy;

    int total = 0;
    int bad   = 0;

    // Memory slave controls and state.
    int          ack_budget = 0;
    int          ack_pct    = 100;
    int          beat_pct   = 100;
    int          stray_pct  = 20;
    int          beat_stop  = BURST;
    bit          slv_busy   = 1'b0;
    int          slv_beats  = 0;
    logic [31:0] slv_addr   = '0;
    logic [31:0] req_log[$];

    logic [31:0] frame_base = '0;
    int          exp_idx    = 0;

    vga_fetch_ctrl #(
        .H_PIXELS   (H_PIXELS),
        .V_LINES    (V_LINES),
        .BURST      (BURST),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .enable      (enable),
        .fb_base     (fb_base),
        .vsync       (vsync),
        .pixel_color (pixel_color),
        .pixel_taken (pixel_taken),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_ack     (mem_ack),
        .mem_rvalid  (mem_rvalid),
        .mem_rdata   (mem_rdata),
        .fifo_level  (fifo_level),
        .underflow   (underflow),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    // Pixel stored at a byte address: a hash so that misordered or stale data shows up.
    function automatic logic [23:0] pix(input logic [31:0] a);
        logic [31:0] h;
        h = a * 32'h9E37_79B1;
        return h[31:8];
    endfunction

    initial begin : mem_slave
        logic [31:0] r;
        mem_ack    = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata  = '0;
        forever begin
            @(posedge clk);
            #1;
            mem_ack    = 1'b0;
            mem_rvalid = 1'b0;
            r          = $urandom;
            mem_rdata  = r;
            if (!reset_n) begin
                slv_busy = 1'b0;
            end else if (!slv_busy) begin
                if (mem_req && ack_budget > 0 && $urandom_range(0, 99) < ack_pct) begin
                    mem_ack    = 1'b1;
                    ack_budget = ack_budget - 1;
                    slv_addr   = mem_addr;
                    slv_beats  = 0;
                    slv_busy   = 1'b1;
                    req_log.push_back(mem_addr);
                end else if ($urandom_range(0, 99) < stray_pct) begin
                    mem_rvalid = 1'b1;
                end
            end else if (slv_beats < beat_stop && $urandom_range(0, 99) < beat_pct) begin
                mem_rvalid = 1'b1;
                mem_rdata  = {r[7:0], pix(slv_addr + 32'(4 * slv_beats))};
                slv_beats  = slv_beats + 1;
                if (slv_beats == BURST) slv_busy = 1'b0;
            end
        end
    end

    task automatic test_reset();
        reset_n = 1'b1;
        #3;
        reset_n = 1'b0;
        #1;
        total++;
        if ({mem_req, busy, underflow} !== 3'b000) begin
            bad++; $display("FAIL reset_ctrl got=%b want=000", {mem_req, busy, underflow});
        end
        total++;
        if (fifo_level !== 7'd0 || pixel_color !== 24'h0) begin
            bad++; $display("FAIL reset_fifo got=%0h/%0h want=0/0", fifo_level, pixel_color);
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_first_burst();
        req_log.delete();
        ack_budget = 1; ack_pct = 100; beat_pct = 100; beat_stop = BURST;
        frame_base = 32'h0010_0000; exp_idx = 0;
        vsync = 1'b1; enable = 1'b1; fb_base = frame_base;
        @(negedge clk);
        total++;
        if (busy !== 1'b0) begin bad++; $display("FAIL pre_vsync_busy got=%b want=0", busy); end
        @(posedge clk); #1;
        vsync = 1'b0; fb_base = 32'hDEAD_BEE0;
        @(negedge clk);
        total++;
        if (busy !== 1'b1 || mem_req !== 1'b0) begin
            bad++; $display("FAIL req_early got=%b%b want=10", busy, mem_req);
        end
        @(negedge clk);
        total++;
        if (mem_req !== 1'b1) begin bad++; $display("FAIL req_latency got=%b want=1", mem_req); end
        total++;
        if (mem_addr !== frame_base) begin
            bad++; $display("FAIL first_addr got=%h want=%h", mem_addr, frame_base);
        end
        repeat (16) @(negedge clk);
        total++;
        if (fifo_level !== 7'd8) begin bad++; $display("FAIL burst_level got=%0d want=8", fifo_level); end
        total++;
        if (pixel_color !== pix(frame_base)) begin
            bad++; $display("FAIL burst_head got=%h want=%h", pixel_color, pix(frame_base));
        end
        total++;
        if (mem_req !== 1'b1 || mem_addr !== frame_base + 32'h20) begin
            bad++; $display("FAIL next_addr got=%b/%h want=1/%h", mem_req, mem_addr, frame_base + 32'h20);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_backpressure();
        int seen;
        bit found;
        ack_budget = 1000;
        repeat (150) @(posedge clk);
        @(negedge clk);
        total++;
        if (fifo_level !== 7'd64) begin bad++; $display("FAIL fill_level got=%0d want=64", fifo_level); end
        seen = 0;
        repeat (20) begin
            @(negedge clk);
            if (mem_req) seen++;
        end
        total++;
        if (seen != 0) begin bad++; $display("FAIL full_no_req got=%0d want=0", seen); end
        @(posedge clk); #1;
        for (int i = 0; i < 8; i++) begin
            pixel_taken = 1'b1;
            @(negedge clk);
            total++;
            if (pixel_color !== pix(frame_base + 32'(4 * exp_idx)) || mem_req !== 1'b0) begin
                bad++; $display("FAIL bp_pop%0d got=%h/%b want=%h/0", i, pixel_color, mem_req,
                                pix(frame_base + 32'(4 * exp_idx)));
            end
            exp_idx++;
            @(posedge clk); #1;
        end
        pixel_taken = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 2 && !found; i++) begin
            @(negedge clk);
            if (mem_req) found = 1'b1;
        end
        total++;
        if (!found || mem_addr !== frame_base + 32'h100) begin
            bad++; $display("FAIL req_after_pops got=%b/%h want=1/%h", found, mem_addr,
                            frame_base + 32'h100);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_full_frame();
        int cyc;
        int seen;
        ack_pct = 70; beat_pct = 70; ack_budget = 1000; beat_stop = BURST;
        cyc = 0;
        while (exp_idx < FRAME_WORDS && cyc < 5000) begin
            pixel_taken = (fifo_level != 0) && ($urandom_range(0, 99) < 60);
            @(negedge clk);
            if (pixel_taken) begin
                total++;
                if (pixel_color !== pix(frame_base + 32'(4 * exp_idx))) begin
                    bad++; $display("FAIL frame_pix%0d got=%h want=%h", exp_idx, pixel_color,
                                    pix(frame_base + 32'(4 * exp_idx)));
                end
                exp_idx++;
            end
            @(posedge clk); #1;
            cyc++;
        end
        pixel_taken = 1'b0;
        total++;
        if (exp_idx != FRAME_WORDS) begin
            bad++; $display("FAIL frame_timeout got=%0d want=%0d", exp_idx, FRAME_WORDS);
        end
        @(negedge clk);
        total++;
        if ({busy, underflow, fifo_level} !== 9'd0) begin
            bad++; $display("FAIL frame_end got=%b/%b/%0d want=0/0/0", busy, underflow, fifo_level);
        end
        total++;
        if (req_log.size() != FRAME_BURSTS) begin
            bad++; $display("FAIL burst_count got=%0d want=%0d", req_log.size(), FRAME_BURSTS);
        end
        for (int k = 0; k < req_log.size() && k < FRAME_BURSTS; k++) begin
            total++;
            if (req_log[k] !== frame_base + 32'(32 * k)) begin
                bad++; $display("FAIL burst_addr%0d got=%h want=%h", k, req_log[k],
                                frame_base + 32'(32 * k));
            end
        end
        seen = 0;
        repeat (30) begin
            @(negedge clk);
            if (mem_req) seen++;
        end
        total++;
        if (seen != 0) begin bad++; $display("FAIL idle_no_req got=%0d want=0", seen); end
        @(posedge clk); #1;
    endtask

    task automatic test_underflow();
        ack_budget = 0;
        pixel_taken = 1'b1;
        @(negedge clk);
        total++;
        if (pixel_color !== 24'h0) begin bad++; $display("FAIL uf_color got=%h want=0", pixel_color); end
        @(posedge clk); #1;
        pixel_taken = 1'b0;
        @(negedge clk);
        total++;
        if (underflow !== 1'b1 || fifo_level !== 7'd0) begin
            bad++; $display("FAIL uf_set got=%b/%0d want=1/0", underflow, fifo_level);
        end
        repeat (5) @(negedge clk);
        total++;
        if (underflow !== 1'b1) begin bad++; $display("FAIL uf_hold got=%b want=1", underflow); end
        @(posedge clk); #1;
        req_log.delete();
        frame_base = 32'h0030_0000; exp_idx = 0;
        vsync = 1'b1; enable = 1'b1; fb_base = frame_base;
        @(posedge clk); #1;
        vsync = 1'b0;
        @(negedge clk);
        total++;
        if (underflow !== 1'b0) begin bad++; $display("FAIL uf_clear got=%b want=0", underflow); end
        @(posedge clk); #1;
    endtask

    task automatic test_mid_burst_vsync();
        int  leak;
        bit  found;
        ack_pct = 100; beat_pct = 100; beat_stop = 3; ack_budget = 1;
        repeat (20) @(posedge clk);
        @(negedge clk);
        total++;
        if (fifo_level !== 7'd3 || pixel_color !== pix(frame_base)) begin
            bad++; $display("FAIL mid_partial got=%0d/%h want=3/%h", fifo_level, pixel_color,
                            pix(frame_base));
        end
        @(posedge clk); #1;
        req_log.delete();
        frame_base = 32'h0020_0000; exp_idx = 0;
        vsync = 1'b1; enable = 1'b1; fb_base = frame_base;
        @(posedge clk); #1;
        vsync = 1'b0; fb_base = 32'h0; beat_stop = BURST;
        @(negedge clk);
        total++;
        if (fifo_level !== 7'd0) begin bad++; $display("FAIL mid_flush got=%0d want=0", fifo_level); end
        leak = 0; found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clk);
            if (fifo_level != 0) leak++;
            if (mem_req) found = 1'b1;
        end
        total++;
        if (leak != 0) begin bad++; $display("FAIL mid_swallow got=%0d want=0", leak); end
        total++;
        if (!found || mem_addr !== frame_base) begin
            bad++; $display("FAIL mid_restart got=%b/%h want=1/%h", found, mem_addr, frame_base);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_vsync_disable();
        int  leak;
        int  seen;
        bit  idle;
        ack_pct = 100; beat_pct = 100; beat_stop = 3; ack_budget = 1;
        frame_base = 32'h0040_0000; exp_idx = 0;
        vsync = 1'b1; enable = 1'b1; fb_base = frame_base;
        @(posedge clk); #1;
        vsync = 1'b0;
        repeat (20) @(posedge clk);
        @(negedge clk);
        total++;
        if (fifo_level !== 7'd3) begin bad++; $display("FAIL dis_partial got=%0d want=3", fifo_level); end
        @(posedge clk); #1;
        vsync = 1'b1; enable = 1'b0; fb_base = 32'h0050_0000;
        @(posedge clk); #1;
        vsync = 1'b0; enable = 1'b1; beat_stop = BURST; ack_budget = 1000;
        @(negedge clk);
        total++;
        if (fifo_level !== 7'd0 || busy !== 1'b1) begin
            bad++; $display("FAIL dis_flush got=%0d/%b want=0/1", fifo_level, busy);
        end
        leak = 0; idle = 1'b0;
        for (int i = 0; i < 40 && !idle; i++) begin
            @(negedge clk);
            if (fifo_level != 0) leak++;
            if (!busy) idle = 1'b1;
        end
        total++;
        if (!idle || leak != 0) begin
            bad++; $display("FAIL dis_idle got=%b/%0d want=1/0", idle, leak);
        end
        seen = 0;
        repeat (20) begin
            @(negedge clk);
            if (mem_req) seen++;
        end
        total++;
        if (seen != 0) begin bad++; $display("FAIL dis_no_req got=%0d want=0", seen); end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid_burst();
        int seen;
        ack_pct = 100; beat_pct = 100; beat_stop = 3; ack_budget = 1;
        frame_base = 32'h0060_0000;
        vsync = 1'b1; enable = 1'b1; fb_base = frame_base;
        @(posedge clk); #1;
        vsync = 1'b0; pixel_taken = 1'b1;
        @(posedge clk); #1;
        pixel_taken = 1'b0;
        repeat (20) @(posedge clk);
        @(negedge clk);
        total++;
        if (fifo_level !== 7'd3 || underflow !== 1'b1 || busy !== 1'b1) begin
            bad++; $display("FAIL rst_pre got=%0d/%b/%b want=3/1/1", fifo_level, underflow, busy);
        end
        #2;
        reset_n = 1'b0;
        #1;
        total++;
        if ({mem_req, busy, underflow} !== 3'b000) begin
            bad++; $display("FAIL rst_mid_ctrl got=%b want=000", {mem_req, busy, underflow});
        end
        total++;
        if (fifo_level !== 7'd0 || pixel_color !== 24'h0) begin
            bad++; $display("FAIL rst_mid_fifo got=%0d/%h want=0/0", fifo_level, pixel_color);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1; beat_stop = BURST; ack_budget = 1000;
        seen = 0;
        repeat (10) begin
            @(negedge clk);
            if (mem_req || busy) seen++;
        end
        total++;
        if (seen != 0) begin bad++; $display("FAIL rst_stays_idle got=%0d want=0", seen); end
    endtask

    initial begin
        reset_n = 1'b1; enable = 1'b0; vsync = 1'b0; fb_base = '0; pixel_taken = 1'b0;
        test_reset();
        test_first_burst();
        test_backpressure();
        test_full_frame();
        test_underflow();
        test_mid_burst_vsync();
        test_full_frame();
        test_vsync_disable();
        test_reset_mid_burst();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
